// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM register slice: SPI event codes, register map,
// controller state encoding and STATUS bit positions.
package pwm_pkg;

   localparam logic [1:0] EVENT_NONE  = 2'b00;
   localparam logic [1:0] EVENT_READ  = 2'b10;
   localparam logic [1:0] EVENT_WRITE = 2'b11;

   localparam logic [6:0] ADDR_CTRL      = 7'h00;
   localparam logic [6:0] ADDR_PERIOD    = 7'h01;
   localparam logic [6:0] ADDR_STATUS    = 7'h02;
   localparam logic [6:0] ADDR_ID        = 7'h03;
   localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_COMMIT = 1;

   localparam int STAT_PENDING     = 0;
   localparam int STAT_BAD_ADDR    = 1;
   localparam int STAT_SHADOW_PEND = 2;

   localparam logic [7:0] PERIOD_RST = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC_WR,
      ST_EXEC_RD,
      ST_WAIT_REL
   } state_e;

   // DUTY registers occupy 0x10 .. 0x10+n_ch-1 inside the 0x10..0x1F window.
   function automatic logic is_duty(input logic [6:0] addr, input int n_ch);
      return (addr[6:4] == ADDR_DUTY_BASE[6:4]) && (int'(addr[3:0]) < n_ch);
   endfunction

endpackage

// File: rtl/event_sync.sv
// Brings the SPI event code into the system clock domain and qualifies it once
// both bits have been stable for a full cycle.
module event_sync
   import pwm_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] b_event_i,
   output logic       ev_valid,
   output logic [1:0] ev_code
);

   logic [1:0] meta_q;
   logic [1:0] ev_s_q;
   logic [1:0] ev_p_q;

   // NOTE: non-blocking assignments make the three stages shift as one chain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= EVENT_NONE;
         ev_s_q <= EVENT_NONE;
         ev_p_q <= EVENT_NONE;
      end else begin
         meta_q <= b_event_i;
         ev_s_q <= meta_q;
         ev_p_q <= ev_s_q;
      end
   end

   // Requiring ev_s == ev_p rejects the transient code seen when the bits skew.
   assign ev_code  = ev_s_q;
   assign ev_valid = (ev_s_q == ev_p_q) && (ev_s_q != EVENT_NONE);

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register bank behind the SPI slave: executes one access per SPI transaction,
// holds PWM shadow registers and commits them on a PWM period boundary.
module spi_reg_ctrl
   import pwm_pkg::*;
#(
   parameter int         N_CH     = 4,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        b_addr_i,
   input  logic [7:0]        b_data_i,
   input  logic [1:0]        b_event_i,
   input  logic              pwm_sync_i,
   output logic [7:0]        b_data_o,
   output logic              enable_o,
   output logic [7:0]        period_o,
   output logic [8*N_CH-1:0] duty_o
);

   logic                  ev_valid;
   logic [1:0]            ev_code;
   state_e                state_q, state_d;
   logic                  cap_en, wr_en, rd_en;
   logic [6:0]            acc_addr_q;
   logic [7:0]            acc_data_q;
   logic                  enable_q, pending_q, bad_addr_q, shadow_pend_q;
   logic [7:0]            period_sh_q, period_q;
   logic [N_CH-1:0][7:0]  duty_sh_q, duty_q;
   logic                  hit_duty, wr_ctrl, wr_period, wr_duty, wr_bad;
   logic                  rd_status, commit;
   logic [6:0]            rd_addr;
   logic [7:0]            rd_mux;
   logic                  unused_rw_flag;

   // The R/W flag is redundant with the event code, so decoding ignores it.
   assign unused_rw_flag = b_addr_i[7];

   event_sync u_event_sync (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .b_event_i (b_event_i),
      .ev_valid  (ev_valid),
      .ev_code   (ev_code)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cap_en  = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ev_valid && ev_code == EVENT_WRITE) begin
               state_d = ST_EXEC_WR;
               cap_en  = 1'b1;
            end else if (ev_valid && ev_code == EVENT_READ) begin
               state_d = ST_EXEC_RD;
               cap_en  = 1'b1;
            end
         end
         ST_EXEC_WR: begin
            wr_en   = 1'b1;
            state_d = ST_WAIT_REL;
         end
         ST_EXEC_RD: begin
            rd_en   = 1'b1;
            state_d = ST_WAIT_REL;
         end
         ST_WAIT_REL: begin
            if (ev_code == EVENT_NONE) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_addr_q <= '0;
         acc_data_q <= '0;
      end else if (cap_en) begin
         acc_addr_q <= b_addr_i[6:0];
         if (state_d == ST_EXEC_WR) acc_data_q <= b_data_i;
      end
   end

   assign hit_duty  = is_duty(acc_addr_q, N_CH);
   assign wr_ctrl   = wr_en && (acc_addr_q == ADDR_CTRL);
   assign wr_period = wr_en && (acc_addr_q == ADDR_PERIOD);
   assign wr_duty   = wr_en && hit_duty;
   assign wr_bad    = wr_en && !(wr_ctrl || wr_period || wr_duty);
   assign rd_status = rd_en && (acc_addr_q == ADDR_STATUS);
   assign commit    = pending_q && pwm_sync_i;

   // NOTE: shadow registers are reset explicitly so they match the active reset values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enable_q      <= 1'b0;
         pending_q     <= 1'b0;
         bad_addr_q    <= 1'b0;
         shadow_pend_q <= 1'b0;
         period_sh_q   <= PERIOD_RST;
         period_q      <= PERIOD_RST;
         duty_sh_q     <= '0;
         duty_q        <= '0;
      end else begin
         if (commit) begin
            period_q  <= period_sh_q;
            duty_q    <= duty_sh_q;
            pending_q <= 1'b0;
         end
         // A commit request in the same cycle as a sync wins over the clear above.
         if (wr_ctrl) begin
            enable_q <= acc_data_q[CTRL_ENABLE];
            if (acc_data_q[CTRL_COMMIT]) pending_q <= 1'b1;
         end
         if (wr_period) period_sh_q <= acc_data_q;
         for (int i = 0; i < N_CH; i++) begin
            if (wr_duty && acc_addr_q[3:0] == 4'(i)) duty_sh_q[i] <= acc_data_q;
         end
         if ((wr_period || wr_duty) && pending_q) shadow_pend_q <= 1'b1;
         if (wr_bad) bad_addr_q <= 1'b1;
         if (rd_status) begin
            bad_addr_q    <= 1'b0;
            shadow_pend_q <= 1'b0;
         end
      end
   end

   // Read data follows the live address so it is ready inside the SPI read window.
   assign rd_addr = b_addr_i[6:0];

   always_comb begin
      rd_mux = '0;
      case (rd_addr)
         ADDR_CTRL: begin
            rd_mux[CTRL_ENABLE] = enable_q;
            rd_mux[CTRL_COMMIT] = pending_q;
         end
         ADDR_PERIOD: rd_mux = period_sh_q;
         ADDR_STATUS: begin
            rd_mux[STAT_PENDING]     = pending_q;
            rd_mux[STAT_BAD_ADDR]    = bad_addr_q;
            rd_mux[STAT_SHADOW_PEND] = shadow_pend_q;
         end
         ADDR_ID: rd_mux = ID_VALUE;
         default: begin
            for (int i = 0; i < N_CH; i++) begin
               if (is_duty(rd_addr, N_CH) && rd_addr[3:0] == 4'(i)) rd_mux = duty_sh_q[i];
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) b_data_o <= '0;
      else       b_data_o <= rd_mux;
   end

   assign enable_o = enable_q;
   assign period_o = period_q;
   assign duty_o   = duty_q;

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-bank controller behind the SPI slave: takes the SPI block's address/data/event bus (SPI clock domain), brings events into the system clock domain, executes register writes and read side effects, and serves read data back. Holds shadow copies of PWM period and per-channel duty. Copies the shadows to the active outputs on a commit request aligned to the PWM period boundary. Sits between the SPI slave and the PWM channel generators.

## Interface
- `N_CH`, 4: number of PWM channels; legal range 1..16.
- `ID_VALUE`, 8'hA5: constant returned by the ID register.

- `clk_i`  in  1  system clock; must be at least 4× the SPI clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `b_addr_i`  in  8  address byte from SPI. Bit 7 is the R/W flag; bits 6:0 are the register address.
- `b_data_i`  in  8  write data from SPI.
- `b_event_i`  in  2  SPI event: 00 none, 10 read, 11 write. Asynchronous to `clk_i`.
- `pwm_sync_i`  in  1  one-cycle pulse at each PWM period boundary.
- `b_data_o`  out  8  read data to SPI.
- `enable_o`  out  1  PWM global enable (CTRL bit 0).
- `period_o`  out  8  active period.
- `duty_o`  out  8·N_CH  active duty values; channel i is at bits [8i+7:8i].

## Operation
- Register map, using `b_addr_i[6:0]`:
  - 0x00 CTRL: bit0 is enable (R/W). Bit1 is commit; writing 1 sets pending. Bit1 reads as pending.
  - 0x01 PERIOD: shadow register, R/W.
  - 0x02 STATUS: read-only.
    - bit0: commit pending.
    - bit1: sticky bad-address write.
    - bit2: sticky shadow-write-while-pending.
  - 0x03 ID: returns `ID_VALUE`.
  - 0x10+i, i<N_CH: DUTY[i] shadow register, R/W.
  - Any other address reads 0x00.
  - Writes to read-only or unmapped addresses set STATUS bit1 and change nothing else.
- Event synchronizer:
  - 2-flop synchronizer on each bit of `b_event_i`, giving `ev_s`, plus one history register `ev_p`.
  - An event qualifies when `ev_s == ev_p` and `ev_s != 00`. This rejects skew when both bits change together.
- FSM:
  - IDLE → EXEC_WR if the qualified event is 11. Latch `b_addr_i` and `b_data_i` on this transition.
  - IDLE → EXEC_RD if the qualified event is 10. Latch `b_addr_i` on this transition.
  - EXEC_WR: perform the write; → WAIT_REL.
  - EXEC_RD: apply read side effects (reading STATUS clears bits 1 and 2; bit0 is untouched); → WAIT_REL.
  - WAIT_REL → IDLE when `ev_s == 00`, i.e. chip select has been released.
  - At most one access is executed per SPI transaction.
- Commit:
  - When pending=1 and `pwm_sync_i`=1, copy PERIOD and all DUTY shadows to `period_o`/`duty_o` and clear pending.
  - `enable_o` updates immediately on a CTRL write, without waiting for a commit.
- Simultaneous events:
  - CTRL commit write in the same cycle as `pwm_sync_i`: pending becomes 1. The copy happens on the next sync, not this one.
  - Shadow write in the same cycle as a commit copy: the active outputs take the old shadow value, and the shadow takes the new value.
  - Shadow write while pending=1: the write succeeds and STATUS bit2 is set.
- Reset values:
  - Outputs: `b_data_o`=0, `enable_o`=0, `period_o`=0xFF, `duty_o`=0.
  - Internal: all shadows match the active reset values; pending=0, sticky bits=0, state IDLE, synchronizers=0.
  - A reset mid-transaction drops the access. The FSM then waits in IDLE for the next qualified nonzero event; an event still held at 10/11 after reset is accepted once.

## Timing
- `b_data_o` is registered every `clk_i` cycle from a read mux indexed directly by `b_addr_i[6:0]`, not the synchronized path. It is valid 1 cycle after `b_addr_i` changes, which covers the SPI slave's 1.5-SPI-clock read window.
- Write latency: `b_event_i` settles before edge 1 → `ev_s` valid at edge 2 → `ev_p` valid at edge 3 → state EXEC_WR at edge 4 → register updated at edge 5. Asynchronous sampling can add one cycle.
- Commit latency: active outputs change on the `clk_i` edge that samples `pwm_sync_i`=1 with pending=1.
- STATUS clear on read happens at the edge that leaves EXEC_RD. The value already shifted out to the master is the pre-clear value.

## Structure
- Shared package `pwm_pkg`:
  - register address constants;
  - `EVENT_READ`=2'b10 and `EVENT_WRITE`=2'b11, shared with the SPI slave;
  - FSM state encoding;
  - STATUS bit indices.
- One sub-module, `event_sync`: the 2-flop synchronizer plus stability qualifier. It outputs `ev_valid` and `ev_code[1:0]`.

## Test plan
- Reset, then read ID → `b_data_o`=0xA5 and all outputs at reset values.
- Write PERIOD=0x40 and DUTY[2]=0x20, no commit → `period_o` stays 0xFF. Then write CTRL=0x03 and pulse `pwm_sync_i` → `period_o`=0x40, duty ch2=0x20, `enable_o`=1, STATUS bit0=0.
- CTRL commit write landing in the same cycle as `pwm_sync_i` → no copy on that cycle; copy on the next pulse.
- Write DUTY[0] while pending → STATUS reads 0x05. A second STATUS read returns 0x01.
- Write to 0x7F → STATUS bit1=1; registers unchanged.
- Drive `b_event_i` 00→11 with a 1-cycle skew between the bits → exactly one write executes. Assert `rst_i` while in WAIT_REL → outputs return to reset values.
